// File: rtl/xy_step_gen.sv
// xy_step_gen: turns a divider quotient (step period) plus a step count and
// direction into a train of fixed-width step pulses for one stepper axis.
// Latency: start accepted at edge T0 -> step/busy high from T0+1; registered outputs.
// Backpressure: none; start while busy is ignored, abort stops the move next cycle.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, period, steps,      move request and its parameters (sampled in IDLE only)
//   dir_in, div_error, abort   direction, divider error qualifier, move abort
//   step, dir, busy, done, err registered outputs
module xy_step_gen #(
  parameter int PW      = 26,
  parameter int CW      = 16,
  parameter int PULSE_W = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [PW-1:0] period,
  input  logic [CW-1:0] steps,
  input  logic          dir_in,
  input  logic          div_error,
  input  logic          abort,
  output logic          step,
  output logic          dir,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  localparam logic [PW-1:0] PULSE_LEN = PW'(PULSE_W);
  localparam logic [PW-1:0] MIN_PER   = PW'(2 * PULSE_W);
  localparam logic [PW-1:0] ONE_P     = PW'(1);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;     // phase down-counter, reloaded at each phase start
  logic [PW-1:0] low_q, low_d;     // low-phase length, Peff - PULSE_W
  logic [CW-1:0] rem_q, rem_d;     // steps still to be issued, including the current one
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    low_d   = low_q;
    rem_d   = rem_q;
    step_d  = step_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        step_d = 1'b0;
        busy_d = 1'b0;
        // abort has no meaning here, so a simultaneous start simply proceeds
        if (start) begin
          if (div_error) begin
            err_d = 1'b1;
          end else begin
            dir_d = dir_in;
            if (steps == '0) begin
              done_d = 1'b1;
            end else begin
              rem_d = steps;
              // Clamping Peff to 2*PULSE_W keeps the low phase >= PULSE_W,
              // so the subtraction below never underflows.
              low_d   = (period < MIN_PER) ? PULSE_LEN : (period - PULSE_LEN);
              cnt_d   = PULSE_LEN - ONE_P;
              step_d  = 1'b1;
              busy_d  = 1'b1;
              state_d = S_HIGH;
            end
          end
        end
      end

      S_HIGH: begin
        if (abort) begin
          state_d = S_IDLE;
          step_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_LOW;
          step_d  = 1'b0;
          cnt_d   = low_q - ONE_P;
        end else begin
          cnt_d = cnt_q - ONE_P;
        end
      end

      S_LOW: begin
        if (abort) begin
          state_d = S_IDLE;
          step_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          rem_d = rem_q - ONE_C;
          if (rem_q == ONE_C) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_HIGH;
            step_d  = 1'b1;
            cnt_d   = PULSE_LEN - ONE_P;
          end
        end else begin
          cnt_d = cnt_q - ONE_P;
        end
      end

      default: begin
        state_d = S_IDLE;
        step_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      low_q   <= '0;
      rem_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign step = step_q;
  assign dir  = dir_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_xy_step_gen.sv
// tb_xy_step_gen: scoreboard bench for xy_step_gen.
// Expected rise/width/done cycles are queued when a move is launched; a
// negedge monitor queues what the DUT produced and each test task compares.
module tb_xy_step_gen;
  localparam int PW = 26;
  localparam int CW = 16;
  localparam int PULSE_W = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] period = '0;
  logic [CW-1:0] steps = '0;
  logic          dir_in = 1'b0;
  logic          div_error = 1'b0;
  logic          abort = 1'b0;
  logic          step, dir, busy, done, err;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;

  int exp_rise[$], exp_width[$], exp_done[$];
  int obs_rise[$], obs_width[$], obs_done[$], obs_err[$];
  logic prev_step = 1'b0;
  int last_rise = 0;

  xy_step_gen #(.PW(PW), .CW(CW), .PULSE_W(PULSE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .period(period), .steps(steps),
    .dir_in(dir_in), .div_error(div_error), .abort(abort),
    .step(step), .dir(dir), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records what the DUT actually did, sampled on negedge.
  always @(negedge clk) begin
    if (step === 1'b1 && prev_step === 1'b0) begin
      obs_rise.push_back(cyc);
      last_rise = cyc;
    end
    if (step === 1'b0 && prev_step === 1'b1) obs_width.push_back(cyc - last_rise);
    if (done === 1'b1) obs_done.push_back(cyc);
    if (err === 1'b1) obs_err.push_back(cyc);
    prev_step = step;
  end

  task automatic clear_queues();
    exp_rise.delete(); exp_width.delete(); exp_done.delete();
    obs_rise.delete(); obs_width.delete(); obs_done.delete(); obs_err.delete();
  endtask

  // Called at a negedge; returns at the next negedge, where the first step
  // of an accepted move is already visible (t0).
  task automatic drive_start(input int p, input int s, input bit d, input bit e, output int t0);
    period = PW'(p); steps = CW'(s); dir_in = d; div_error = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0; div_error = 1'b0;
    t0 = cyc;
  endtask

  task automatic test_reset();
    int t0;
    tests_run++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step got=%b exp=0", step); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (dir !== 1'b0) begin fails++; $display("FAIL reset_dir got=%b exp=0", dir); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    drive_start(200, 3, 1'b1, 1'b0, t0);
    repeat (10) @(negedge clk);
    tests_run++; if (step !== 1'b1) begin fails++; $display("FAIL pre_reset_step got=%b exp=1", step); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if ({step, busy, dir, done, err} !== 5'b0)
      begin fails++; $display("FAIL async_reset outs got=%b exp=00000", {step, busy, dir, done, err}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_queues();
  endtask

  task automatic test_normal();
    int t0, e, o, busy_cnt, dir_bad;
    bit seen;
    clear_queues();
    drive_start(200, 3, 1'b1, 1'b0, t0);
    for (int k = 0; k < 3; k++) begin exp_rise.push_back(t0 + k * 200); exp_width.push_back(PULSE_W); end
    exp_done.push_back(t0 + 600);
    busy_cnt = 0; dir_bad = 0; seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (done === 1'b1) seen = 1;
      else begin
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b1 && dir !== 1'b1) dir_bad++;
        @(negedge clk);
      end
    end
    repeat (2) @(negedge clk);
    tests_run++; if (!seen) begin fails++; $display("FAIL normal_done_timeout got=none exp=done"); end
    tests_run++; if (busy_cnt != 600) begin fails++; $display("FAIL normal_busy_cycles got=%0d exp=600", busy_cnt); end
    tests_run++; if (dir_bad != 0) begin fails++; $display("FAIL normal_dir_stable got=%0d bad exp=0", dir_bad); end
    tests_run++; if (obs_rise.size() != exp_rise.size())
      begin fails++; $display("FAIL normal_pulse_count got=%0d exp=%0d", obs_rise.size(), exp_rise.size()); end
    while (exp_rise.size() > 0 && obs_rise.size() > 0) begin
      e = exp_rise.pop_front(); o = obs_rise.pop_front();
      tests_run++; if (o != e) begin fails++; $display("FAIL normal_rise got=%0d exp=%0d", o, e); end
    end
    while (exp_width.size() > 0 && obs_width.size() > 0) begin
      e = exp_width.pop_front(); o = obs_width.pop_front();
      tests_run++; if (o != e) begin fails++; $display("FAIL normal_width got=%0d exp=%0d", o, e); end
    end
    e = exp_done.pop_front(); o = (obs_done.size() > 0) ? obs_done.pop_front() : -1;
    tests_run++; if (o != e) begin fails++; $display("FAIL normal_done_cycle got=%0d exp=%0d", o, e); end
  endtask

  task automatic test_clamp();
    int t0, e, o;
    clear_queues();
    drive_start(30, 2, 1'b0, 1'b0, t0);
    for (int k = 0; k < 2; k++) begin exp_rise.push_back(t0 + k * 100); exp_width.push_back(PULSE_W); end
    exp_done.push_back(t0 + 200);
    repeat (230) @(negedge clk);
    tests_run++; if (obs_rise.size() != exp_rise.size())
      begin fails++; $display("FAIL clamp_pulse_count got=%0d exp=%0d", obs_rise.size(), exp_rise.size()); end
    while (exp_rise.size() > 0 && obs_rise.size() > 0) begin
      e = exp_rise.pop_front(); o = obs_rise.pop_front();
      tests_run++; if (o != e) begin fails++; $display("FAIL clamp_rise got=%0d exp=%0d", o, e); end
    end
    while (exp_width.size() > 0 && obs_width.size() > 0) begin
      e = exp_width.pop_front(); o = obs_width.pop_front();
      tests_run++; if (o != e) begin fails++; $display("FAIL clamp_width got=%0d exp=%0d", o, e); end
    end
    e = exp_done.pop_front(); o = (obs_done.size() > 0) ? obs_done.pop_front() : -1;
    tests_run++; if (o != e) begin fails++; $display("FAIL clamp_done_cycle got=%0d exp=%0d", o, e); end
    tests_run++; if (dir !== 1'b0) begin fails++; $display("FAIL clamp_dir got=%b exp=0", dir); end
  endtask

  task automatic test_zero_steps();
    int t0;
    clear_queues();
    drive_start(200, 0, 1'b1, 1'b0, t0);
    tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done got=%b exp=1", done); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy got=%b exp=0", busy); end
    tests_run++; if (dir !== 1'b1) begin fails++; $display("FAIL zero_dir_latched got=%b exp=1", dir); end
    repeat (20) @(negedge clk);
    tests_run++; if (obs_rise.size() != 0) begin fails++; $display("FAIL zero_pulses got=%0d exp=0", obs_rise.size()); end
    tests_run++; if (obs_done.size() != 1) begin fails++; $display("FAIL zero_done_count got=%0d exp=1", obs_done.size()); end
  endtask

  task automatic test_div_error();
    int t0;
    clear_queues();
    drive_start(200, 5, 1'b0, 1'b1, t0);
    tests_run++; if (err !== 1'b1) begin fails++; $display("FAIL diverr_err got=%b exp=1", err); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL diverr_busy got=%b exp=0", busy); end
    repeat (20) @(negedge clk);
    tests_run++; if (obs_err.size() != 1) begin fails++; $display("FAIL diverr_err_count got=%0d exp=1", obs_err.size()); end
    tests_run++; if (obs_rise.size() != 0) begin fails++; $display("FAIL diverr_pulses got=%0d exp=0", obs_rise.size()); end
    tests_run++; if (obs_done.size() != 0) begin fails++; $display("FAIL diverr_done got=%0d exp=0", obs_done.size()); end
    tests_run++; if (dir !== 1'b1) begin fails++; $display("FAIL diverr_dir_unlatched got=%b exp=1", dir); end
  endtask

  task automatic test_abort();
    int t0, e, o;
    clear_queues();
    drive_start(200, 10, 1'b1, 1'b0, t0);
    for (int k = 0; k < 4; k++) exp_rise.push_back(t0 + k * 200);
    for (int i = 0; i < 800 && cyc < t0 + 605; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++; if (step !== 1'b0) begin fails++; $display("FAIL abort_step got=%b exp=0", step); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
    // A start alongside abort in IDLE must still be accepted.
    repeat (300) @(negedge clk);
    tests_run++; if (obs_rise.size() != 4) begin fails++; $display("FAIL abort_pulse_count got=%0d exp=4", obs_rise.size()); end
    tests_run++; if (obs_done.size() != 0) begin fails++; $display("FAIL abort_done got=%0d exp=0", obs_done.size()); end
    while (exp_rise.size() > 0 && obs_rise.size() > 0) begin
      e = exp_rise.pop_front(); o = obs_rise.pop_front();
      tests_run++; if (o != e) begin fails++; $display("FAIL abort_rise got=%0d exp=%0d", o, e); end
    end
    clear_queues();
    abort = 1'b1;
    drive_start(120, 1, 1'b0, 1'b0, t0);
    abort = 1'b0;
    tests_run++; if (step !== 1'b1 || busy !== 1'b1)
      begin fails++; $display("FAIL abort_start_wins got=%b%b exp=11", step, busy); end
    repeat (130) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t0, t1, e, o;
    bit seen;
    clear_queues();
    drive_start(200, 1, 1'b1, 1'b0, t0);
    exp_rise.push_back(t0); exp_done.push_back(t0 + 200);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (done === 1'b1) seen = 1; else @(negedge clk);
    end
    tests_run++; if (!seen) begin fails++; $display("FAIL b2b_first_done_timeout got=none exp=done"); end
    drive_start(100, 2, 1'b0, 1'b0, t1);
    tests_run++; if (step !== 1'b1) begin fails++; $display("FAIL b2b_first_new_step got=%b exp=1", step); end
    tests_run++; if (dir !== 1'b0) begin fails++; $display("FAIL b2b_dir_switch got=%b exp=0", dir); end
    exp_rise.push_back(t0 + 201); exp_rise.push_back(t0 + 301); exp_done.push_back(t0 + 401);
    repeat (240) @(negedge clk);
    tests_run++; if (t1 != t0 + 201) begin fails++; $display("FAIL b2b_accept_cycle got=%0d exp=%0d", t1, t0 + 201); end
    tests_run++; if (obs_rise.size() != 3) begin fails++; $display("FAIL b2b_pulse_count got=%0d exp=3", obs_rise.size()); end
    while (exp_rise.size() > 0 && obs_rise.size() > 0) begin
      e = exp_rise.pop_front(); o = obs_rise.pop_front();
      tests_run++; if (o != e) begin fails++; $display("FAIL b2b_rise got=%0d exp=%0d", o, e); end
    end
    while (exp_done.size() > 0) begin
      e = exp_done.pop_front(); o = (obs_done.size() > 0) ? obs_done.pop_front() : -1;
      tests_run++; if (o != e) begin fails++; $display("FAIL b2b_done_cycle got=%0d exp=%0d", o, e); end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_normal();
    test_clamp();
    test_zero_steps();
    test_div_error();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
